send_moves: RTL
===============

# send_moves

Transmit side of the inter-board move link. Accepts one-hot local move pulses (left/right/put), queues them, and drives them onto the three opponent data lines (`left_data`, `right_data`, `send_data`). Each move becomes a clean high pulse of fixed length followed by a guaranteed low gap, so the remote board's synchronizer and edge detector see exactly one rising edge per move. Sits between the local input conditioning and the board-to-board pins.

## Interface
- `HOLD`, default 4: cycles each data line is held high per move; ≥2.
- `GAP`, default 4: minimum low cycles on all lines between consecutive moves; ≥2.
- `DEPTH`, default 4: move queue entries; power of two, ≥2.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `lrp_self`  in  3  local move pulse, one cycle per move; [2]=left, [1]=right, [0]=put.
- `enable`  in  1  transmit permitted (link up / our turn); gates dequeue only.
- `flush`  in  1  synchronous; discards all queued, not-yet-started moves.
- `left_data`  out  1  line to opponent: left.
- `right_data`  out  1  line to opponent: right.
- `send_data`  out  1  line to opponent: put.
- `busy`  out  1  high when a pulse or gap is in progress or the queue is non-empty.
- `overflow`  out  1  one-cycle pulse when a move is dropped because the queue is full.

## Operation
- Input decode: any bit of `lrp_self` set = one move. Non-one-hot input resolves left > right > put. At most one move is taken per cycle.
- Queue: `DEPTH`-entry FIFO of a 2-bit move code. Push on a decoded move. Pop when the FSM starts a pulse. Read data is show-ahead.
- Full queue: a push with no same-cycle pop is dropped and `overflow` pulses. A push and pop in the same cycle on a full queue are both accepted.
- FSM states and transitions:
  - IDLE, all lines low:
    - If `enable` and queue non-empty: pop, load the counter with HOLD-1, go to PULSE.
  - PULSE, the line selected by the popped code is high and the others low:
    - Counter decrements to 0, then load GAP-1 and go to GAP.
  - GAP, all lines low:
    - Counter decrements to 0, then go to IDLE.
- `enable` low: no new pop. A PULSE or GAP already in progress completes normally. Queue contents are retained.
- `flush`: empties the FIFO and discards any same-cycle push. Does not truncate the current PULSE or GAP.
- Output lines are registered and are a direct decode of state plus the latched code. There is no combinational path from inputs to lines.

## Timing
- Reset (async assert): state IDLE, FIFO empty, counter 0, latched code cleared. All of `left_data`, `right_data`, `send_data`, `busy` and `overflow` are 0. A mid-pulse reset drops the line immediately.
- Latency: a move sampled at edge k into an empty, idle, enabled block pops at edge k+1. Its line is high from edge k+1 to edge k+1+HOLD, i.e. exactly HOLD cycles.
- Minimum spacing: move-to-move period is HOLD+GAP+1 cycles, since IDLE is one cycle.
- Back-to-back: queued moves go out in order, each separated by GAP low cycles plus one IDLE cycle.
- `busy` is registered. It rises at the edge after the first push and falls on the edge the FSM returns to IDLE with the queue empty.
- `overflow` is registered and asserts in the cycle after the dropped push.
- Counter width is $clog2(max(HOLD,GAP)).

## Structure
- Shared package `link_pkg`:
  - `move_t` enum {MV_LEFT, MV_RIGHT, MV_PUT}, 2 bits.
  - `tx_state_t` enum {TX_IDLE, TX_PULSE, TX_GAP}.
  - Default HOLD, GAP and DEPTH constants.
- One sub-module, `move_fifo`: parameterized DEPTH synchronous FIFO with push, pop, flush, rdata, empty and full.
- Top level contains the decoder, the FSM, the counter and the output registers.

## Test plan
- Reset, then a single put pulse at edge 10 with HOLD=4, GAP=4 → `send_data` high during cycles 11–14, low from 15. Other lines stay 0. `busy` falls by cycle 20.
- Three moves L, R, P on consecutive cycles → `left_data`, `right_data` and `send_data` pulse in that order, each 4 cycles high, rising edges 9 cycles apart, no overlap.
- `enable`=0 while pushing 4 moves, then a 5th push → `overflow` pulses once and no line toggles. Raising `enable` → exactly 4 pulses in order.
- Non-one-hot input `lrp_self`=3'b011 → one `right_data` pulse only.
- `flush` during the PULSE of the first of 3 queued moves → the current pulse completes its full HOLD, and the remaining 2 moves are never sent.
- `rst` asserted mid-PULSE → the line goes low asynchronously. After release the block is idle and the queue is empty.

Source files
------------

// File: rtl/link_pkg.sv
// Shared types and defaults for the inter-board move link.
package link_pkg;

    typedef enum logic [1:0] {MV_LEFT, MV_RIGHT, MV_PUT} move_t;
    typedef enum logic [1:0] {TX_IDLE, TX_PULSE, TX_GAP} tx_state_t;

    localparam int DEF_HOLD  = 4;
    localparam int DEF_GAP   = 4;
    localparam int DEF_DEPTH = 4;

    // Priority decode of a raw move pulse vector: left > right > put.
    function automatic move_t decode_move(input logic [2:0] lrp);
        if (lrp[2])      return MV_LEFT;
        else if (lrp[1]) return MV_RIGHT;
        else             return MV_PUT;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Small show-ahead FIFO of move codes with synchronous flush.
module move_fifo
    import link_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  logic  flush,
    input  move_t wdata,
    output move_t rdata,
    output logic  empty,
    output logic  full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    move_t         mem [DEPTH];
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the same cycle frees a slot.
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = mem[rptr];

    // Pointer and occupancy tracking; flush wins over everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/send_moves.sv
// Move transmitter: queues local moves and emits fixed-length, gap-separated line pulses.
module send_moves
    import link_pkg::*;
#(
    parameter int HOLD  = DEF_HOLD,
    parameter int GAP   = DEF_GAP,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] lrp_self,
    input  logic       enable,
    input  logic       flush,
    output logic       left_data,
    output logic       right_data,
    output logic       send_data,
    output logic       busy,
    output logic       overflow
);

    localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = $clog2(MAXC);

    tx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    move_t         code, code_n;
    move_t         mv, rdata;
    logic          push, pop, empty, full;

    assign push = |lrp_self;
    assign mv   = decode_move(lrp_self);

    move_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (mv),
        .rdata (rdata),
        .empty (empty),
        .full  (full)
    );

    // Next-state logic: IDLE pops into PULSE, PULSE times out into GAP, GAP back to IDLE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = code;
        pop     = 1'b0;
        case (state)
            TX_IDLE: begin
                if (enable && !empty) begin
                    pop     = 1'b1;
                    code_n  = rdata;
                    cnt_n   = CW'(HOLD - 1);
                    state_n = TX_PULSE;
                end
            end
            TX_PULSE: begin
                if (cnt == '0) begin
                    cnt_n   = CW'(GAP - 1);
                    state_n = TX_GAP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            TX_GAP: begin
                if (cnt == '0) state_n = TX_IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = TX_IDLE;
        endcase
    end

    // State, counter, latched code and registered line/status outputs.
    // Lines decode the next state so the pulse starts on the popping edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= TX_IDLE;
            cnt        <= '0;
            code       <= MV_LEFT;
            left_data  <= 1'b0;
            right_data <= 1'b0;
            send_data  <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            code       <= code_n;
            left_data  <= (state_n == TX_PULSE) && (code_n == MV_LEFT);
            right_data <= (state_n == TX_PULSE) && (code_n == MV_RIGHT);
            send_data  <= (state_n == TX_PULSE) && (code_n == MV_PUT);
            // Uses the pre-edge queue view so busy rises one edge after the first push.
            busy       <= (state_n != TX_IDLE) || !empty;
            overflow   <= push && full && !pop && !flush;
        end
    end

endmodule
